mips_muldiv: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS CPU, sitting directly downstream of the ALU control decoder alongside the main ALU. It consumes the resolved 6-bit function code and, for MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns the HI/LO register pair. It signals `busy` so the CPU can stall MFHI/MFLO and further mul/div issue until results are committed.

---
 rtl/mips_muldiv.sv | 171 +++++++++++++++++
 tb/tb_mips_muldiv.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// mips_muldiv: multi-cycle multiply/divide unit that owns the MIPS HI/LO pair.
// MULT/MULTU use 32 shift-add steps, DIV/DIVU use 32 restoring shift-subtract
// steps on unsigned magnitudes. A final FIX cycle applies the sign correction
// and writes hi/lo. MTHI/MTLO write hi/lo directly in one edge.
//
// Handshake: an instruction is taken on a rising edge where start=1, busy=0
// and fncode is a recognised code. start while busy=1 is dropped, including
// MTHI/MTLO. busy rises on the accept edge of a mul/div and falls on the edge
// that writes hi/lo, so the first cycle with busy=0 already shows the result.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       fncode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] LAST     = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   busy_next;

    // Latched operation context
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;

    // Issue decode
    logic             is_mul_op, is_div_op, is_signed;
    logic             accept, mt_ok;
    logic             a_neg, b_neg, div_zero;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fixed;

    assign dbg_state = state;

    // Decode the issuing instruction and form operand magnitudes.
    // A zero divisor keeps the raw dividend so the remainder comes out as op_a.
    always_comb begin
        is_mul_op = (fncode == FN_MULT) || (fncode == FN_MULTU);
        is_div_op = (fncode == FN_DIV)  || (fncode == FN_DIVU);
        is_signed = (fncode == FN_MULT) || (fncode == FN_DIV);
        accept    = start && (state == S_IDLE) && (is_mul_op || is_div_op);
        mt_ok     = start && (state == S_IDLE);
        a_neg     = is_signed && op_a[WIDTH-1];
        b_neg     = is_signed && op_b[WIDTH-1];
        div_zero  = is_div_op && (op_b == '0);
        mag_a     = (a_neg && !div_zero) ? (-op_a) : op_a;
        mag_b     = b_neg ? (-op_b) : op_b;
    end

    // One multiply step (add then shift right) and one restoring divide step.
    // In divide mode acc holds {remainder, dividend/quotient bits}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc[WIDTH-2:0], div_ge};
    end

    // Sign correction applied on the FIX edge.
    always_comb begin
        prod_fixed = neg_q ? (-acc) : acc;
        fix_lo     = op_div ? (neg_q ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0])
                            : prod_fixed[WIDTH-1:0];
        fix_hi     = op_div ? (neg_r ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH])
                            : prod_fixed[2*WIDTH-1:WIDTH];
    end

    // Next-state logic; busy is the registered image of "next state not idle".
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (cnt == LAST) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        busy_next = (state_next != S_IDLE);
    end

    // State and busy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
        end
    end

    // Datapath: latch on accept, iterate in RUN, commit hi/lo on FIX or MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_div <= is_div_op;
                        neg_q  <= (a_neg ^ b_neg) && !div_zero;
                        neg_r  <= a_neg && !div_zero;
                        cnt    <= '0;
                        if (is_div_op) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end else if (mt_ok && fncode == FN_MTHI) begin
                        hi <= op_a;
                    end else if (mt_ok && fncode == FN_MTLO) begin
                        lo <= op_a;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 6'd1;
                    acc <= op_div ? div_next : mul_next;
                end
                S_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: scenario tasks for the HI/LO multiply/divide unit.
// Expected {hi,lo} pairs are queued at issue time and popped when busy drops.
module tb_mips_muldiv;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  fncode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_bad;
    logic [63:0] exp_q[$];

    mips_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fncode    (fncode),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic built on the simulator's own operators.
    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic signed [31:0] q, r;
        model = '0;
        case (fn)
            FN_MULT: begin
                sa = 64'($signed(a));
                sb = 64'($signed(b));
                sp = sa * sb;
                model = sp;
            end
            FN_MULTU: model = {32'd0, a} * {32'd0, b};
            FN_DIV: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    model = {r, q};
                end
            end
            FN_DIVU: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
            default: model = '0;
        endcase
    endfunction

    // Issue one mul/div at the current negedge, then follow it to completion.
    task automatic do_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        logic [63:0] old;
        logic [63:0] want;
        int n;
        bit held;
        old = {hi, lo};
        start = 1'b1; fncode = fn; op_a = a; op_b = b;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        n = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if ({hi, lo} !== old) held = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (n !== 33) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d want 33", name, n);
        end
        n_cmp++;
        if (!held) begin
            n_bad++;
            $display("FAIL %s hold: hi/lo changed while busy, old %h", name, old);
        end
        want = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== want) begin
            n_bad++;
            $display("FAIL %s result: got %h_%h want %h_%h", name, hi, lo,
                     want[63:32], want[31:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; fncode = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++;
        if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++;
        if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        bit busy_seen;
        busy_seen = 1'b0;
        start = 1'b1; fncode = FN_MTHI; op_a = 32'h1234; op_b = 32'h9999;
        @(negedge clk);
        if (busy !== 1'b0) busy_seen = 1'b1;
        n_cmp++;
        if (hi !== 32'h1234) begin n_bad++; $display("FAIL mthi_latency: got %h want 00001234", hi); end
        fncode = FN_MTLO; op_a = 32'h5678;
        @(negedge clk);
        if (busy !== 1'b0) busy_seen = 1'b1;
        start = 1'b0;
        n_cmp++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_bad++;
            $display("FAIL mthi_mtlo: got %h_%h want 00001234_00005678", hi, lo);
        end
        @(negedge clk);
        if (busy !== 1'b0) busy_seen = 1'b1;
        n_cmp++;
        if (busy_seen) begin n_bad++; $display("FAIL mt_busy: got busy=1 want 0"); end
    endtask

    task automatic test_unknown_code();
        logic [63:0] old;
        old = {hi, lo};
        start = 1'b1; fncode = 6'b100000; op_a = 32'hAAAA_5555; op_b = 32'h3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || {hi, lo} !== old) begin
            n_bad++;
            $display("FAIL unknown_code: got busy=%b hilo=%h want busy=0 hilo=%h", busy, {hi, lo}, old);
        end
    endtask

    // Spec vectors, issued back-to-back in the first cycle busy=0.
    task automatic test_back_to_back();
        do_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        do_op("mult_neg",  FN_MULT,  32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        do_op("mult_min",  FN_MULT,  32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});
        do_op("div_neg",   FN_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op("divu",      FN_DIVU,  32'd100,       32'd7,         {32'd2,         32'd14});
        do_op("div_ovf",   FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        do_op("div_rsgn",  FN_DIV,   32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD});
    endtask

    task automatic test_div_zero();
        do_op("divu_zero", FN_DIVU, 32'h64,        32'd0, {32'h0000_0064, 32'hFFFF_FFFF});
        do_op("div_zero",  FN_DIV,  32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF});
    endtask

    // MTHI and a second MULT issued mid-operation must both be dropped.
    task automatic test_busy_ignore();
        logic [63:0] old;
        logic [63:0] want;
        int n;
        bit held;
        @(negedge clk);
        old = {hi, lo};
        start = 1'b1; fncode = FN_MULTU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        held = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if ({hi, lo} !== old) held = 1'b0;
            if (n == 5) begin
                start = 1'b1; fncode = FN_MTHI; op_a = 32'hDEAD;
            end else if (n == 20) begin
                start = 1'b1; fncode = FN_MULT; op_a = 32'd2; op_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (n !== 33) begin n_bad++; $display("FAIL ignore_busy_cycles: got %0d want 33", n); end
        n_cmp++;
        if (!held) begin n_bad++; $display("FAIL ignore_hold: hi/lo changed while busy, old %h", old); end
        want = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== want) begin
            n_bad++;
            $display("FAIL ignore_result: got %h_%h want %h_%h", hi, lo, want[63:32], want[31:0]);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_restart: got busy=%b want 0", busy); end
    endtask

    task automatic test_abort();
        start = 1'b1; fncode = FN_MTHI; op_a = 32'hAAAA;
        @(negedge clk);
        start = 1'b1; fncode = FN_MULTU; op_a = 32'd5; op_b = 32'd5;
        exp_q.push_back({32'd0, 32'd25});
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        do_op("reissue", FN_MULTU, 32'd5, 32'd5, {32'd0, 32'd25});
    endtask

    task automatic test_random();
        logic [5:0] fns[4];
        logic [5:0] fn;
        logic [31:0] a, b;
        fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;
        for (int i = 0; i < 10; i++) begin
            fn = fns[$urandom_range(0, 3)];
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            do_op("random", fn, a, b, model(fn, a, b));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mthi_mtlo();
        test_unknown_code();
        test_back_to_back();
        test_div_zero();
        test_busy_ignore();
        test_abort();
        test_random();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
